agc_gain_ctrl: RTL
==================

# agc_gain_ctrl

Closed-loop AGC gain controller that sits directly downstream of the complex multiplier and closes the loop back to its B operand. It takes scaled complex samples from the multiplier, computes instantaneous power I²+Q², averages it over a fixed window, compares the average against a target with hysteresis and steps a saturating gain word. That gain word drives the multiplier's `b_real`; `b_imag` is tied to 0 by the integrator.

## Interface
- `DWIDTH`, 16: signed width of `in_real` and `in_imag`; the integrator selects the slice of the multiplier output.
- `GWIDTH`, 16: gain word width, signed Q2.14.
- `LOG2_WIN`, 8: averaging window of 2^LOG2_WIN accepted samples; legal range 2..16.
- `TARGET`, 32'h1000_0000: target average power (2*DWIDTH bits, unsigned).
- `HYST`, 32'h0200_0000: dead-band half-width; must satisfy HYST ≤ TARGET.
- `GAIN_INIT`, 16'h4000: reset gain (1.0).
- `GAIN_MIN` / `GAIN_MAX`, 16'h0040 / 16'h7FFF: gain saturation limits.
- `STEP_UP` / `STEP_DN`, 16'h0040 / 16'h0100: gain increment / decrement per window.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  sample qualifier.
- `in_real`, `in_imag`  in  DWIDTH  signed sample.
- `freeze`  in  1  hold gain; averaging continues.
- `gain`  out  GWIDTH  current gain to multiplier.
- `gain_valid`  out  1  one-cycle pulse after each gain evaluation.
- `power`  out  2*DWIDTH  last window average, unsigned.
- `power_valid`  out  1  one-cycle pulse when `power` updates.
- `locked`  out  1  last average was inside the dead-band.

## Operation
- **Datapath pipeline**, advanced only by the valid bit it carries:
  - S1 registers the inputs when `in_valid` is high.
  - S2 registers I² and Q², each unsigned 2*DWIDTH.
  - S3 registers the sum, 2*DWIDTH bits. Max 2·2^30 = 2^31 fits in 32 bits, so no overflow.
- **Accumulator**: 2*DWIDTH+LOG2_WIN bits, with a window counter of LOG2_WIN bits.
  - Each S3-valid cycle adds the sum and increments the counter.
  - On the last sample of a window (counter = all ones), `power` ← (acc+sum) >> LOG2_WIN (truncating). In the same cycle the accumulator is cleared, the counter wraps to 0 and `power_valid` pulses.
  - No sample is ever dropped. Samples arriving during COMPARE/UPDATE go into the next window.
- **FSM** with states ACCUM, COMPARE, UPDATE:
  - ACCUM → COMPARE on the window-end cycle.
  - COMPARE registers two flags, taking exactly 1 cycle:
    - `above` = power > TARGET+HYST, computed in 2*DWIDTH+1 bits.
    - `below` = power < TARGET−HYST.
  - UPDATE takes 1 cycle, then returns to ACCUM:
    - If `above`: gain ← max(gain−STEP_DN, GAIN_MIN).
    - If `below`: gain ← min(gain+STEP_UP, GAIN_MAX).
    - Otherwise gain is held.
    - Saturation is computed in GWIDTH+1 bits, so the gain never wraps.
    - `locked` ← !above && !below.
    - `gain_valid` pulses.
- **freeze** is sampled in UPDATE. When high: gain and `locked` are held and `gain_valid` does not pulse. `power_valid` still pulses.
- **In-flight samples**: LOG2_WIN ≥ 2 guarantees the next window end cannot arrive before the FSM is back in ACCUM.

## Timing
- **Reset values** (all immediate, no clock required):
  - `gain` = GAIN_INIT.
  - `power` = 0, `power_valid` = 0, `gain_valid` = 0, `locked` = 0.
  - Accumulator, counter and pipeline valids = 0; FSM in ACCUM.
- **Latency**, for the last sample of a window captured at edge k:
  - `power` / `power_valid` are valid after edge k+3.
  - COMPARE occurs at k+4.
  - `gain` / `gain_valid` / `locked` are updated after edge k+5.
- **Reset mid-window**: the partial window is discarded. The first `power_valid` after release needs a full 2^LOG2_WIN new samples.
- **Throughput**: `in_valid` may be high every cycle or have arbitrary gaps. Gaps stall nothing and only delay the window end.

## Configuration
- `AGC_FAST_ATTACK_EN` defined:
  - In COMPARE, also flag `big` = power ≥ TARGET<<2, computed in 2*DWIDTH+2 bits.
  - In UPDATE, when `above && big`, the decrement is STEP_DN<<2. Saturation at GAIN_MIN is unchanged.
- `AGC_FAST_ATTACK_EN` undefined: the decrement is always STEP_DN and no `big` logic exists.

## Test plan
All scenarios use LOG2_WIN=2 and default parameters otherwise.
1. **Reset**: assert `rst` without clock → `gain`=0x4000, `power`=0, all valids 0, `locked`=0.
2. **In dead-band**: 4 samples I=0x4000, Q=0 → `power`=0x1000_0000 three cycles after the 4th capture. Two cycles later `gain_valid` pulses, `gain` stays 0x4000 and `locked`=1.
3. **Above target**: 4 samples I=Q=0x7FFF → `power`=0x7FFE_0002 and `gain`=0x3F00. With `AGC_FAST_ATTACK_EN` defined, `gain`=0x3C00.
4. **Saturation at GAIN_MAX**: 4-sample windows of zeros repeated 500 times → `gain` rises by 0x40 per window and saturates at 0x7FFF with no wrap; `locked`=0 throughout.
5. **Freeze and gaps**: `freeze`=1 with I=Q=0x7FFF and `in_valid` toggling 1-0-1-0 → `power_valid` pulses after every 4 accepted samples; `gain` held at 0x4000; no `gain_valid`.
6. **Reset mid-window**: pulse `rst` after 2 samples, then send 4 samples of I=0x4000 → exactly one `power_valid`, with `power`=0x1000_0000.

Source files
------------

// File: rtl/agc_gain_ctrl.sv
// Closed-loop AGC gain controller: windowed I^2+Q^2 average, hysteretic compare, saturating gain step.
// Optional feature macro: AGC_FAST_ATTACK_EN (quadruple decrement when far above target).
module agc_gain_ctrl #(
    parameter int unsigned          DWIDTH    = 16,
    parameter int unsigned          GWIDTH    = 16,
    parameter int unsigned          LOG2_WIN  = 8,
    parameter logic [2*DWIDTH-1:0]  TARGET    = 32'h1000_0000,
    parameter logic [2*DWIDTH-1:0]  HYST      = 32'h0200_0000,
    parameter logic [GWIDTH-1:0]    GAIN_INIT = 16'h4000,
    parameter logic [GWIDTH-1:0]    GAIN_MIN  = 16'h0040,
    parameter logic [GWIDTH-1:0]    GAIN_MAX  = 16'h7FFF,
    parameter logic [GWIDTH-1:0]    STEP_UP   = 16'h0040,
    parameter logic [GWIDTH-1:0]    STEP_DN   = 16'h0100
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic signed [DWIDTH-1:0]   in_real,
    input  logic signed [DWIDTH-1:0]   in_imag,
    input  logic                       freeze,
    output logic [GWIDTH-1:0]          gain,
    output logic                       gain_valid,
    output logic [2*DWIDTH-1:0]        power,
    output logic                       power_valid,
    output logic                       locked
);

    localparam int unsigned PW = 2 * DWIDTH;
    localparam int unsigned AW = PW + LOG2_WIN;

    localparam logic [PW:0]               HI_THR    = {1'b0, TARGET} + {1'b0, HYST};
    localparam logic [PW-1:0]             LO_THR    = TARGET - HYST;
    localparam logic signed [GWIDTH:0]    G_MIN_X   = {1'b0, GAIN_MIN};
    localparam logic signed [GWIDTH:0]    G_MAX_X   = {1'b0, GAIN_MAX};
    localparam logic signed [GWIDTH:0]    STEP_UP_X = {1'b0, STEP_UP};
    localparam logic signed [GWIDTH:0]    STEP_DN_X = {1'b0, STEP_DN};
`ifdef AGC_FAST_ATTACK_EN
    localparam logic [PW+1:0]             BIG_THR    = {TARGET, 2'b00};
    localparam logic signed [GWIDTH:0]    STEP_BIG_X = {1'b0, STEP_DN[GWIDTH-3:0], 2'b00};
`endif

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        COMPARE = 2'd1,
        UPDATE  = 2'd2
    } state_e;

    logic                      s1_v_q;
    logic signed [DWIDTH-1:0]  s1_re_q, s1_im_q;
    logic                      s2_v_q;
    logic [PW-1:0]             s2_sqr_q, s2_sqi_q;
    logic                      s3_v_q;
    logic [PW-1:0]             s3_sum_q;
    logic [AW-1:0]             acc_q;
    logic [LOG2_WIN-1:0]       cnt_q;
    logic [PW-1:0]             power_q;
    logic                      power_valid_q;

    state_e                    state_q, state_d;
    logic                      above_q, above_d, below_q, below_d;
`ifdef AGC_FAST_ATTACK_EN
    logic                      big_q, big_d;
`endif
    logic [GWIDTH-1:0]         gain_q, gain_d;
    logic                      locked_q, locked_d;
    logic                      gain_valid_q, gain_valid_d;

    logic signed [PW-1:0]      re_x_s, im_x_s;
    logic [PW-1:0]             sqr_s, sqi_s;
    logic [AW-1:0]             acc_sum_s;
    logic                      win_end_s;
    logic signed [GWIDTH:0]    g_x_s, dn_step_s, dn_x_s, up_x_s;
    logic [GWIDTH-1:0]         dn_sat_s, up_sat_s;

    // Squares and accumulator sum; both squares fit in PW bits even for the most negative input.
    always_comb begin
        re_x_s    = {{DWIDTH{s1_re_q[DWIDTH-1]}}, s1_re_q};
        im_x_s    = {{DWIDTH{s1_im_q[DWIDTH-1]}}, s1_im_q};
        sqr_s     = $unsigned(re_x_s * re_x_s);
        sqi_s     = $unsigned(im_x_s * im_x_s);
        acc_sum_s = acc_q + AW'(s3_sum_q);
        win_end_s = s3_v_q && (cnt_q == {LOG2_WIN{1'b1}});
    end

    // Datapath pipeline and window accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_q        <= 1'b0;
            s1_re_q       <= '0;
            s1_im_q       <= '0;
            s2_v_q        <= 1'b0;
            s2_sqr_q      <= '0;
            s2_sqi_q      <= '0;
            s3_v_q        <= 1'b0;
            s3_sum_q      <= '0;
            acc_q         <= '0;
            cnt_q         <= '0;
            power_q       <= '0;
            power_valid_q <= 1'b0;
        end else begin
            s1_v_q <= in_valid;
            if (in_valid) begin
                s1_re_q <= in_real;
                s1_im_q <= in_imag;
            end
            s2_v_q <= s1_v_q;
            if (s1_v_q) begin
                s2_sqr_q <= sqr_s;
                s2_sqi_q <= sqi_s;
            end
            s3_v_q <= s2_v_q;
            if (s2_v_q) begin
                s3_sum_q <= s2_sqr_q + s2_sqi_q;
            end
            power_valid_q <= win_end_s;
            if (s3_v_q) begin
                if (win_end_s) begin
                    power_q <= PW'(acc_sum_s >> LOG2_WIN);
                    acc_q   <= '0;
                    cnt_q   <= '0;
                end else begin
                    acc_q   <= acc_sum_s;
                    cnt_q   <= cnt_q + {{(LOG2_WIN-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    // Saturating gain candidates, evaluated one bit wider so they never wrap.
    always_comb begin
        g_x_s = {gain_q[GWIDTH-1], gain_q};
`ifdef AGC_FAST_ATTACK_EN
        if (big_q) begin
            dn_step_s = STEP_BIG_X;
        end else begin
            dn_step_s = STEP_DN_X;
        end
`else
        dn_step_s = STEP_DN_X;
`endif
        dn_x_s = g_x_s - dn_step_s;
        up_x_s = g_x_s + STEP_UP_X;
        if (dn_x_s < G_MIN_X) begin
            dn_sat_s = GAIN_MIN;
        end else begin
            dn_sat_s = dn_x_s[GWIDTH-1:0];
        end
        if (up_x_s > G_MAX_X) begin
            up_sat_s = GAIN_MAX;
        end else begin
            up_sat_s = up_x_s[GWIDTH-1:0];
        end
    end

    // Control FSM: next state, compare flags and gain update.
    always_comb begin
        state_d      = state_q;
        above_d      = above_q;
        below_d      = below_q;
`ifdef AGC_FAST_ATTACK_EN
        big_d        = big_q;
`endif
        gain_d       = gain_q;
        locked_d     = locked_q;
        gain_valid_d = 1'b0;
        case (state_q)
            ACCUM: begin
                if (win_end_s) begin
                    state_d = COMPARE;
                end else begin
                    state_d = ACCUM;
                end
            end
            COMPARE: begin
                above_d = ({1'b0, power_q} > HI_THR);
                below_d = (power_q < LO_THR);
`ifdef AGC_FAST_ATTACK_EN
                big_d   = ({2'b00, power_q} >= BIG_THR);
`endif
                state_d = UPDATE;
            end
            UPDATE: begin
                state_d = ACCUM;
                if (!freeze) begin
                    gain_valid_d = 1'b1;
                    locked_d     = !above_q && !below_q;
                    if (above_q) begin
                        gain_d = dn_sat_s;
                    end else if (below_q) begin
                        gain_d = up_sat_s;
                    end else begin
                        gain_d = gain_q;
                    end
                end else begin
                    gain_d = gain_q;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    // Control state and registered gain outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ACCUM;
            above_q      <= 1'b0;
            below_q      <= 1'b0;
`ifdef AGC_FAST_ATTACK_EN
            big_q        <= 1'b0;
`endif
            gain_q       <= GAIN_INIT;
            locked_q     <= 1'b0;
            gain_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            above_q      <= above_d;
            below_q      <= below_d;
`ifdef AGC_FAST_ATTACK_EN
            big_q        <= big_d;
`endif
            gain_q       <= gain_d;
            locked_q     <= locked_d;
            gain_valid_q <= gain_valid_d;
        end
    end

    assign gain        = gain_q;
    assign gain_valid  = gain_valid_q;
    assign power       = power_q;
    assign power_valid = power_valid_q;
    assign locked      = locked_q;

endmodule
